// File: rtl/resp_checker.sv
// Response checker: compares observed f against a latched 16-entry truth table.
// Optional MISR signature output enabled by defining RESP_CHECKER_MISR_EN.
module resp_checker #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [3:0]  in_pat,
  input  logic        in_f,
  input  logic [15:0] exp_tt,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [4:0]  err_cnt,
  output logic        first_err_vld,
  output logic [3:0]  first_err_idx,
`ifdef RESP_CHECKER_MISR_EN
  output logic [15:0] cov,
  output logic [15:0] signature
`else
  output logic [15:0] cov
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int IW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TO_LIM = IW'(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic [15:0]   exp_q, exp_d;
  logic [15:0]   cov_q, cov_d;
  logic [4:0]    err_q, err_d;
  logic          fev_q, fev_d;
  logic [3:0]    fei_q, fei_d;
  logic          to_q, to_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [3:0]    idx;
  logic [15:0]   cov_set;
  logic [IW-1:0] idle_inc;
  logic          mis;

  // Pattern bit 0 is the table index MSB.
  assign idx      = {in_pat[0], in_pat[1], in_pat[2], in_pat[3]};
  assign cov_set  = cov_q | (16'd1 << idx);
  assign idle_inc = idle_q + IW'(1);
  assign mis      = (in_f != exp_q[idx]);

`ifdef RESP_CHECKER_MISR_EN
  logic [15:0] sig_q, sig_d;
  logic [15:0] sig_nx;

  assign sig_nx = {sig_q[14:0], 1'b0}
                ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                ^ {11'b0, idx, in_f};

  // Signature: reseed on start, fold each accepted sample in RUN.
  always_comb begin
    sig_d = sig_q;
    if (start)
      sig_d = 16'hFFFF;
    else if (state_q == S_RUN && in_valid)
      sig_d = sig_nx;
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 16'hFFFF;
    else        sig_q <= sig_d;
  end

  assign signature = sig_q;
`endif

  // Next-state: start wins over everything, samples only count in RUN.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    cov_d   = cov_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    to_d    = to_q;
    idle_d  = idle_q;
    if (start) begin
      state_d = S_RUN;
      exp_d   = exp_tt;
      cov_d   = 16'h0000;
      err_d   = 5'd0;
      fev_d   = 1'b0;
      fei_d   = 4'd0;
      to_d    = 1'b0;
      idle_d  = '0;
    end else if (state_q == S_RUN) begin
      if (in_valid) begin
        cov_d  = cov_set;
        idle_d = '0;
        if (mis) begin
          if (err_q != 5'd31)
            err_d = err_q + 5'd1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = idx;
          end
        end
        if (cov_set == 16'hFFFF)
          state_d = S_DONE;
      end else begin
        idle_d = idle_inc;
        if (idle_inc == TO_LIM) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      exp_q   <= 16'h0000;
      cov_q   <= 16'h0000;
      err_q   <= 5'd0;
      fev_q   <= 1'b0;
      fei_q   <= 4'd0;
      to_q    <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      cov_q   <= cov_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
    end
  end

  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_q == 5'd0) && !to_q;
  assign timeout       = to_q;
  assign err_cnt       = err_q;
  assign first_err_vld = fev_q;
  assign first_err_idx = fei_q;
  assign cov           = cov_q;

endmodule

// File: tb/tb_resp_checker.sv
// Directed testbench for resp_checker (TIMEOUT=8).
// Signature checks compile in when RESP_CHECKER_MISR_EN is defined.
module tb_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_pat = 4'd0;
  logic        in_f = 1'b0;
  logic [15:0] exp_tt = 16'h0000;
  logic        busy, done, pass, timeout;
  logic [4:0]  err_cnt;
  logic        first_err_vld;
  logic [3:0]  first_err_idx;
  logic [15:0] cov;
`ifdef RESP_CHECKER_MISR_EN
  logic [15:0] signature;
  logic [15:0] sig_m;
  logic [15:0] sig_pass;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  resp_checker #(.TIMEOUT(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_valid(in_valid),
    .in_pat(in_pat),
    .in_f(in_f),
    .exp_tt(exp_tt),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .err_cnt(err_cnt),
    .first_err_vld(first_err_vld),
    .first_err_idx(first_err_idx),
`ifdef RESP_CHECKER_MISR_EN
    .cov(cov),
    .signature(signature)
`else
    .cov(cov)
`endif
  );

  function automatic logic [3:0] rev4(input int i);
    logic [3:0] v;
    v = i[3:0];
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic par(input int i);
    logic [3:0] v;
    v = i[3:0];
    return ^v;
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s,
                                       input int i, input logic f);
    logic [3:0] v;
    v = i[3:0];
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
         ^ {11'b0, v, f};
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input logic [15:0] tt);
    start = 1'b1;
    exp_tt = tt;
    @(negedge clk);
    start = 1'b0;
`ifdef RESP_CHECKER_MISR_EN
    sig_m = 16'hFFFF;
`endif
  endtask

  // One sample; returns at the negedge after its sampling edge.
  task automatic drive(input int i, input logic f);
    in_valid = 1'b1;
    in_pat = rev4(i);
    in_f = f;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef RESP_CHECKER_MISR_EN
    if (busy || done) sig_m = misr(sig_m, i, f);
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, pass, timeout} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {busy, done, pass, timeout}); end
    checks++; if (err_cnt !== 5'd0 || first_err_vld !== 1'b0 || first_err_idx !== 4'd0) begin errors++; $display("FAIL rst_err got %0d/%b/%0d exp 0/0/0", err_cnt, first_err_vld, first_err_idx); end
    checks++; if (cov !== 16'h0000) begin errors++; $display("FAIL rst_cov got %h exp 0000", cov); end
    start = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_full_pass;
    do_start(16'h6996);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL fp_run got %b exp 10", {busy, done}); end
    for (int i = 0; i < 15; i++) drive(i, par(i));
    checks++; if ({busy, done} !== 2'b10 || cov !== 16'h7FFF) begin errors++; $display("FAIL fp_15 got %b cov %h exp 10 cov 7fff", {busy, done}, cov); end
    drive(15, par(15));
    checks++; if ({busy, done, pass, timeout} !== 4'b0110) begin errors++; $display("FAIL fp_flags got %b exp 0110", {busy, done, pass, timeout}); end
    checks++; if (err_cnt !== 5'd0 || first_err_vld !== 1'b0) begin errors++; $display("FAIL fp_err got %0d/%b exp 0/0", err_cnt, first_err_vld); end
    checks++; if (cov !== 16'hFFFF) begin errors++; $display("FAIL fp_cov got %h exp ffff", cov); end
`ifdef RESP_CHECKER_MISR_EN
    sig_pass = sig_m;
    checks++; if (signature !== sig_m) begin errors++; $display("FAIL fp_sig got %h exp %h", signature, sig_m); end
`endif
    drive(3, 1'b1);
    drive(6, 1'b1);
    checks++; if ({done, pass} !== 2'b11 || err_cnt !== 5'd0 || cov !== 16'hFFFF) begin errors++; $display("FAIL fp_hold got %b err %0d cov %h exp 11 0 ffff", {done, pass}, err_cnt, cov); end
  endtask

  task automatic test_single_fault;
    do_start(16'h6996);
    for (int i = 0; i < 16; i++) drive(i, (i == 5) ? ~par(i) : par(i));
    checks++; if (err_cnt !== 5'd1) begin errors++; $display("FAIL sf_err got %0d exp 1", err_cnt); end
    checks++; if (first_err_vld !== 1'b1 || first_err_idx !== 4'd5) begin errors++; $display("FAIL sf_first got %b/%0d exp 1/5", first_err_vld, first_err_idx); end
    checks++; if ({done, pass, timeout} !== 3'b100) begin errors++; $display("FAIL sf_flags got %b exp 100", {done, pass, timeout}); end
`ifdef RESP_CHECKER_MISR_EN
    checks++; if (signature !== sig_m) begin errors++; $display("FAIL sf_sig got %h exp %h", signature, sig_m); end
    checks++; if (signature === sig_pass) begin errors++; $display("FAIL sf_sig_diff got %h exp not %h", signature, sig_pass); end
`endif
  endtask

  task automatic test_first_err;
    do_start(16'h6996);
    for (int i = 0; i < 10; i++) drive(i, (i == 9) ? ~par(i) : par(i));
    checks++; if (first_err_vld !== 1'b1 || first_err_idx !== 4'd9 || err_cnt !== 5'd1) begin errors++; $display("FAIL fe_mid got %b/%0d/%0d exp 1/9/1", first_err_vld, first_err_idx, err_cnt); end
    for (int i = 10; i < 16; i++) drive(i, (i == 12) ? ~par(i) : par(i));
    checks++; if (first_err_idx !== 4'd9 || err_cnt !== 5'd2 || done !== 1'b1) begin errors++; $display("FAIL fe_end got idx %0d err %0d done %b exp 9 2 1", first_err_idx, err_cnt, done); end
  endtask

  task automatic test_dup_restart;
    do_start(16'h0000);
    repeat (40) drive(3, 1'b1);
    checks++; if (err_cnt !== 5'd31) begin errors++; $display("FAIL dup_sat got %0d exp 31", err_cnt); end
    checks++; if (cov !== 16'h0008 || {busy, done} !== 2'b10) begin errors++; $display("FAIL dup_cov got %h %b exp 0008 10", cov, {busy, done}); end
    checks++; if (first_err_idx !== 4'd3) begin errors++; $display("FAIL dup_idx got %0d exp 3", first_err_idx); end
    start = 1'b1;
    exp_tt = 16'hFFFF;
    in_valid = 1'b1;
    in_pat = rev4(7);
    in_f = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    checks++; if (cov !== 16'h0000 || err_cnt !== 5'd0 || first_err_vld !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rs_clear got cov %h err %0d fev %b busy %b exp 0 0 0 1", cov, err_cnt, first_err_vld, busy); end
    exp_tt = 16'h0000;
    drive(2, 1'b1);
    checks++; if (err_cnt !== 5'd0 || cov !== 16'h0004) begin errors++; $display("FAIL rs_latch got err %0d cov %h exp 0 0004", err_cnt, cov); end
  endtask

  task automatic test_timeout;
    do_start(16'h6996);
    for (int i = 0; i < 3; i++) drive(i, par(i));
    repeat (7) @(negedge clk);
    checks++; if ({busy, done, timeout} !== 3'b100) begin errors++; $display("FAIL to_7 got %b exp 100", {busy, done, timeout}); end
    @(negedge clk);
    checks++; if ({busy, done, pass, timeout} !== 4'b0101) begin errors++; $display("FAIL to_8 got %b exp 0101", {busy, done, pass, timeout}); end
    checks++; if (cov !== 16'h0007 || err_cnt !== 5'd0) begin errors++; $display("FAIL to_cov got %h err %0d exp 0007 0", cov, err_cnt); end
    do_start(16'h6996);
    checks++; if ({busy, done, timeout} !== 3'b100) begin errors++; $display("FAIL to_restart got %b exp 100", {busy, done, timeout}); end
  endtask

  task automatic test_reset_mid;
    do_start(16'h0000);
    for (int i = 0; i < 7; i++) drive(i, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, pass, timeout} !== 4'b0000 || cov !== 16'h0000 || err_cnt !== 5'd0 || first_err_vld !== 1'b0 || first_err_idx !== 4'd0) begin errors++; $display("FAIL rm_clear got %b cov %h err %0d fev %b idx %0d exp all 0", {busy, done, pass, timeout}, cov, err_cnt, first_err_vld, first_err_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 1'b1);
    checks++; if (busy !== 1'b0 || cov !== 16'h0000 || err_cnt !== 5'd0) begin errors++; $display("FAIL rm_ignore got busy %b cov %h err %0d exp 0 0 0", busy, cov, err_cnt); end
    do_start(16'h0000);
    drive(1, 1'b1);
    checks++; if (busy !== 1'b1 || cov !== 16'h0002 || err_cnt !== 5'd1) begin errors++; $display("FAIL rm_start got busy %b cov %h err %0d exp 1 0002 1", busy, cov, err_cnt); end
  endtask

  initial begin
    #3;
    test_reset;
    test_full_pass;
    test_single_fault;
    test_first_err;
    test_dup_restart;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
